imem_load_ctrl: RTL and testbench
=================================

// Module: imem_load_ctrl
// PURPOSE
//  Sequencer for the byte-wide instruction RAM. Owns its MODE/load/DEBUG controls.
//  Accepts a length-prefixed program from the UART RX byte stream and writes it in order.
//  Also steps the RAM's debug read pointer and hands the RAM to the CPU for random-access fetch.
//  Sits between uart_rx, the front-panel buttons and the RAM, all in the 9600 Hz clock domain.
// PARAMETERS
//  DEPTH          6     RAM locations; legal program length 1..DEPTH
//  TIMEOUT_CYCLES 9600  max idle clocks between bytes while loading (1 s @ 9600 Hz)
//  STEP_HOLD      2     clocks ram_debug is held high per step (RAM edge-detect needs >=2)
// PORTS
//  clk        in  1  system clock (9600 Hz)
//  rst        in  1  asynchronous, active-high reset
//  rx_data    in  8  received UART byte
//  rx_valid   in  1  1-clk strobe, rx_data valid
//  load_req   in  1  1-clk pulse: start program load
//  debug_req  in  1  1-clk pulse: enter debug-read mode
//  run_req    in  1  1-clk pulse: hand RAM to CPU
//  abort      in  1  1-clk pulse: return to IDLE from any state
//  step       in  1  1-clk pulse: advance debug read pointer
//  ram_mode   out 2  RAM MODE: 0 write, 1 debug read, 2 CPU fetch
//  ram_data   out 8  RAM write data
//  ram_load   out 1  RAM write strobe, 1 clk
//  ram_debug  out 1  RAM DEBUG level
//  cpu_en     out 1  CPU may fetch/execute
//  loaded     out 1  a valid program is resident
//  byte_count out 4  program bytes written in current/last load
//  err        out 1  sticky: bad length or timeout; cleared by load_req
//  state      out 2  0 IDLE, 1 LOAD, 2 DEBUG, 3 RUN
// BEHAVIOUR
//  - Reset values: state=IDLE, ram_mode=2, ram_data=0, ram_load=0, ram_debug=0, cpu_en=0.
//    Also loaded=0, byte_count=0, err=0; length reg, timer and step counter cleared.
//  - All outputs are registered. ram_mode=2 in IDLE and RUN, 0 in LOAD, 1 in DEBUG.
//  - IDLE always drives mode 2 for >=1 clk first, so the RAM write pointer is zeroed before LOAD.
//  - IDLE priority for same-cycle requests: load_req > debug_req > run_req.
//    debug_req/run_req are ignored unless loaded=1.
//  - In any state, abort wins over every other input.
//    Next state IDLE; ram_load/ram_debug/cpu_en drop on the next clk.
//  - IDLE->LOAD on load_req: clears err, loaded and byte_count, zeroes the timer, awaits the length byte.
//  - LOAD, first rx_valid is the length L, not written to RAM.
//    L==0 or L>DEPTH: err=1 and go to IDLE.
//  - LOAD, data bytes: each later rx_valid gives, next clk, ram_data=rx_data, ram_load=1 for 1 clk, byte_count+1.
//    After the byte with byte_count==L: loaded=1, go to IDLE (ram_mode=2 the clk after the last ram_load).
//  - LOAD timeout: timer counts clks since the last rx_valid (or entry) and saturates at TIMEOUT_CYCLES.
//    At the limit: err=1, loaded=0, go to IDLE. A partial byte_count is kept for debug.
//  - load_req or rx_valid outside LOAD is ignored. rx_valid in the same clk as abort is dropped.
//  - DEBUG: on step, ram_debug=1 for STEP_HOLD clks, then 0 for >=1 clk.
//    Steps arriving while busy are dropped (no queue). Exit only by abort -> IDLE.
//  - RUN: cpu_en=1 one clk after entry, ram_mode=2. Exit only by abort -> IDLE, cpu_en=0 next clk.
//  - byte_count is 4 bits and never exceeds DEPTH; no wrap is possible.
// TESTING
//  1. Reset: rst pulsed mid-LOAD -> all outputs at reset values immediately (async).
//     No ram_load seen after rst rises.
//  2. load_req, then bytes 03,A1,B2,C3 -> three ram_load pulses with data A1,B2,C3; byte_count=3.
//     Then loaded=1, state=IDLE, ram_mode=2.
//  3. load_req, then length 07 (DEPTH=6) -> err=1, IDLE, no ram_load.
//     Repeat with length 00 -> same response.
//  4. load_req, length 04, two bytes, then TIMEOUT_CYCLES silent clks -> err=1, loaded=0, byte_count=2, IDLE.
//  5. loaded=1, debug_req then step -> ram_mode=1; ram_debug high exactly 2 clks.
//     A second step during the hold is dropped.
//  6. loaded=1, run_req, debug_req, load_req in the same clk -> LOAD entered, loaded=0.
//     Later run_req -> RUN with cpu_en=1; abort -> cpu_en=0 next clk.

Source files
------------

// File: rtl/imem_load_ctrl_if.sv
// ---------------------------------------------------------------------------
// imem_load_ctrl_if
// Bundles the request/stream inputs and the RAM/status outputs of the
// instruction-RAM load sequencer.
//   master : the environment side (UART RX, front panel) drives the
//            requests and observes the RAM controls and status
//   slave  : the sequencer itself, which consumes the requests and drives
//            the RAM controls and status
// Signals
//   rx_data[7:0], rx_valid          UART byte stream
//   load_req, debug_req, run_req    1-clk mode requests
//   abort, step                     1-clk pulses
//   ram_mode[1:0]                   0 write, 1 debug read, 2 CPU fetch
//   ram_data[7:0], ram_load         RAM write data and 1-clk strobe
//   ram_debug                       RAM debug-step level
//   cpu_en, loaded, err             status flags
//   byte_count[3:0], state[1:0]     progress and sequencer state
// ---------------------------------------------------------------------------
interface imem_load_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       load_req;
  logic       debug_req;
  logic       run_req;
  logic       abort;
  logic       step;

  logic [1:0] ram_mode;
  logic [7:0] ram_data;
  logic       ram_load;
  logic       ram_debug;
  logic       cpu_en;
  logic       loaded;
  logic [3:0] byte_count;
  logic       err;
  logic [1:0] state;

  modport master (
    output rx_data, rx_valid, load_req, debug_req, run_req, abort, step,
    input  ram_mode, ram_data, ram_load, ram_debug, cpu_en, loaded,
           byte_count, err, state
  );

  modport slave (
    input  rx_data, rx_valid, load_req, debug_req, run_req, abort, step,
    output ram_mode, ram_data, ram_load, ram_debug, cpu_en, loaded,
           byte_count, err, state
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// ---------------------------------------------------------------------------
// imem_load_ctrl
// Sequencer for the byte-wide instruction RAM. Loads a length-prefixed
// program from the UART byte stream, steps the RAM debug read pointer, and
// hands the RAM to the CPU for fetch. All outputs are registered.
// Ports
//   clk  : system clock (9600 Hz)
//   rst  : asynchronous, active-high reset
//   bus  : imem_load_ctrl_if.slave (requests in, RAM controls/status out)
// Parameters
//   DEPTH          : RAM locations, legal program length 1..DEPTH (<=15)
//   TIMEOUT_CYCLES : idle clocks between bytes before a load is abandoned
//   STEP_HOLD      : clocks ram_debug is held high per step
// ---------------------------------------------------------------------------
module imem_load_ctrl #(
  parameter int DEPTH          = 6,
  parameter int TIMEOUT_CYCLES = 9600,
  parameter int STEP_HOLD      = 2
) (
  input  logic              clk,
  input  logic              rst,
  imem_load_ctrl_if.slave   bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(STEP_HOLD + 2);
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] MODE_WRITE = 2'd0;
  localparam logic [1:0] MODE_DEBUG = 2'd1;
  localparam logic [1:0] MODE_CPU   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DEBUG = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      ram_mode_q, ram_mode_d;
  logic [7:0]      ram_data_q, ram_data_d;
  logic            ram_load_q, ram_load_d;
  logic            ram_debug_q, ram_debug_d;
  logic            cpu_en_q, cpu_en_d;
  logic            loaded_q, loaded_d;
  logic [3:0]      byte_count_q, byte_count_d;
  logic            err_q, err_d;
  logic [3:0]      len_q, len_d;
  logic            have_len_q, have_len_d;
  logic            done_q, done_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [SW-1:0]   step_cnt_q, step_cnt_d;
  logic [3:0]      bc_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ram_mode_q   <= MODE_CPU;
      ram_data_q   <= '0;
      ram_load_q   <= 1'b0;
      ram_debug_q  <= 1'b0;
      cpu_en_q     <= 1'b0;
      loaded_q     <= 1'b0;
      byte_count_q <= '0;
      err_q        <= 1'b0;
      len_q        <= '0;
      have_len_q   <= 1'b0;
      done_q       <= 1'b0;
      timer_q      <= '0;
      step_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      ram_mode_q   <= ram_mode_d;
      ram_data_q   <= ram_data_d;
      ram_load_q   <= ram_load_d;
      ram_debug_q  <= ram_debug_d;
      cpu_en_q     <= cpu_en_d;
      loaded_q     <= loaded_d;
      byte_count_q <= byte_count_d;
      err_q        <= err_d;
      len_q        <= len_d;
      have_len_q   <= have_len_d;
      done_q       <= done_d;
      timer_q      <= timer_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ram_data_d   = ram_data_q;
    ram_load_d   = 1'b0;
    ram_debug_d  = 1'b0;
    loaded_d     = loaded_q;
    byte_count_d = byte_count_q;
    err_d        = err_q;
    len_d        = len_q;
    have_len_d   = have_len_q;
    done_d       = 1'b0;
    timer_d      = timer_q;
    step_cnt_d   = '0;
    bc_inc       = byte_count_q + 4'd1;

    if (bus.abort) begin
      // Abort overrides everything, including a same-cycle rx byte.
      state_d    = S_IDLE;
      have_len_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.load_req) begin
            state_d      = S_LOAD;
            err_d        = 1'b0;
            loaded_d     = 1'b0;
            byte_count_d = '0;
            timer_d      = '0;
            len_d        = '0;
            have_len_d   = 1'b0;
          end else if (bus.debug_req && loaded_q) begin
            state_d = S_DEBUG;
          end else if (bus.run_req && loaded_q) begin
            state_d = S_RUN;
          end
        end

        S_LOAD: begin
          if (done_q) begin
            // Last write was issued with MODE still 0; release the RAM now.
            state_d    = S_IDLE;
            loaded_d   = 1'b1;
            have_len_d = 1'b0;
          end else if (bus.rx_valid) begin
            timer_d = '0;
            if (!have_len_q) begin
              if (bus.rx_data == 8'd0 || bus.rx_data > 8'(DEPTH)) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
              end else begin
                len_d      = bus.rx_data[3:0];
                have_len_d = 1'b1;
              end
            end else begin
              ram_data_d   = bus.rx_data;
              ram_load_d   = 1'b1;
              byte_count_d = bc_inc;
              if (bc_inc == len_q) begin
                done_d = 1'b1;
              end
            end
          end else if (timer_q == TIMER_LIMIT) begin
            err_d      = 1'b1;
            loaded_d   = 1'b0;
            state_d    = S_IDLE;
            have_len_d = 1'b0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end

        S_DEBUG: begin
          // step_cnt counts the high phase plus one low clock; a new step is
          // accepted once only the low clock remains.
          if (step_cnt_q > SW'(1)) begin
            step_cnt_d = step_cnt_q - SW'(1);
          end else if (bus.step) begin
            step_cnt_d = SW'(STEP_HOLD + 1);
          end else begin
            step_cnt_d = '0;
          end
          ram_debug_d = (step_cnt_d > SW'(1));
        end

        S_RUN: begin
          state_d = S_RUN;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    case (state_d)
      S_LOAD:  ram_mode_d = MODE_WRITE;
      S_DEBUG: ram_mode_d = MODE_DEBUG;
      default: ram_mode_d = MODE_CPU;
    endcase
    cpu_en_d = (state_d == S_RUN);
  end

  assign bus.state      = state_q;
  assign bus.ram_mode   = ram_mode_q;
  assign bus.ram_data   = ram_data_q;
  assign bus.ram_load   = ram_load_q;
  assign bus.ram_debug  = ram_debug_q;
  assign bus.cpu_en     = cpu_en_q;
  assign bus.loaded     = loaded_q;
  assign bus.byte_count = byte_count_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_load_ctrl
// Directed and randomized checks of the instruction-RAM load sequencer.
// A monitor collects every RAM write; expected writes and flags come from
// the program contents and the length rules (1..DEPTH accepted).
// ---------------------------------------------------------------------------
module tb_imem_load_ctrl;
  localparam int DEPTH          = 6;
  localparam int TIMEOUT_CYCLES = 9600;
  localparam int STEP_HOLD      = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_load_ctrl_if bus ();

  imem_load_ctrl #(
    .DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .STEP_HOLD(STEP_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int loads_in_rst = 0;
  logic [7:0] wr_q[$];
  logic [1:0] wr_mode_q[$];

  // Capture RAM writes away from the active edge.
  always @(negedge clk) begin
    if (bus.ram_load === 1'b1) begin
      if (rst) loads_in_rst++;
      else begin
        wr_q.push_back(bus.ram_data);
        wr_mode_q.push_back(bus.ram_mode);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.load_req = 1'b0;
    bus.debug_req = 1'b0; bus.run_req = 1'b0; bus.abort = 1'b0; bus.step = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data = b; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_load();
    bus.load_req = 1'b1; tick(); bus.load_req = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_state"}, 32'(bus.state), 0);
    chk({p, "_mode"}, 32'(bus.ram_mode), 2);
    chk({p, "_data"}, 32'(bus.ram_data), 0);
    chk({p, "_load"}, 32'(bus.ram_load), 0);
    chk({p, "_debug"}, 32'(bus.ram_debug), 0);
    chk({p, "_cpu_en"}, 32'(bus.cpu_en), 0);
    chk({p, "_loaded"}, 32'(bus.loaded), 0);
    chk({p, "_count"}, 32'(bus.byte_count), 0);
    chk({p, "_err"}, 32'(bus.err), 0);
  endtask

  // Bounded wait for IDLE; an expired bound shows up as a failed check.
  task automatic wait_idle(input string tag);
    for (int i = 0; i < 4 && bus.state !== 2'd0; i++) tick();
    chk({tag, "_idle"}, 32'(bus.state), 0);
  endtask

  task automatic chk_writes(input string tag, input logic [7:0] exp_q[$]);
    chk({tag, "_nwr"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      chk($sformatf("%s_wr%0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
      chk($sformatf("%s_wrmode%0d", tag, i), 32'(wr_mode_q[i]), 0);
    end
  endtask

  // Load a program: length byte then data bytes with random idle gaps.
  // Expectations follow from the length rule alone.
  task automatic load_program(input string tag, input logic [7:0] len, input logic [7:0] data[$]);
    logic [7:0] exp_q[$];
    bit ok;
    ok = (len >= 1) && (len <= DEPTH);
    wr_q.delete(); wr_mode_q.delete();
    pulse_load();
    chk({tag, "_enter"}, 32'(bus.state), 1);
    chk({tag, "_errclr"}, 32'(bus.err), 0);
    send(len);
    if (ok) begin
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        send(data[i]);
        exp_q.push_back(data[i]);
      end
    end
    wait_idle(tag);
    tick();
    chk({tag, "_loaded"}, 32'(bus.loaded), ok ? 1 : 0);
    chk({tag, "_err"}, 32'(bus.err), ok ? 0 : 1);
    chk({tag, "_count"}, 32'(bus.byte_count), ok ? 32'(len) : 0);
    chk({tag, "_mode"}, 32'(bus.ram_mode), 2);
    chk_writes(tag, exp_q);
  endtask

  initial begin
    logic [7:0] prog[$];
    logic [7:0] exp_q[$];
    int highs;
    clear_inputs();
    tick(); tick();
    chk_reset("rst0");
    rst = 1'b0;
    tick();

    // Asynchronous reset in the middle of a load.
    pulse_load();
    send(8'h03);
    send(8'hA1);
    chk("t1_load_pulse", 32'(bus.ram_load), 1);
    #2 rst = 1'b1;
    #1 chk_reset("t1_async");
    tick(); tick();
    chk_reset("t1_hold");
    chk("t1_no_load_in_rst", 32'(loads_in_rst), 0);
    rst = 1'b0;
    tick();

    // Illegal lengths.
    prog = {};
    load_program("t3_len7", 8'h07, prog);
    load_program("t3_len0", 8'h00, prog);

    // debug/run ignored while nothing is loaded.
    bus.debug_req = 1'b1; bus.run_req = 1'b1; tick(); clear_inputs();
    chk("t4_ignored_req", 32'(bus.state), 0);

    // Timeout after two of four bytes.
    wr_q.delete(); wr_mode_q.delete();
    pulse_load();
    send(8'h04); send(8'h11); send(8'h22);
    repeat (TIMEOUT_CYCLES - 1) tick();
    chk("t4_before_limit", 32'(bus.state), 1);
    tick();
    chk("t4_state", 32'(bus.state), 0);
    chk("t4_err", 32'(bus.err), 1);
    chk("t4_loaded", 32'(bus.loaded), 0);
    chk("t4_count", 32'(bus.byte_count), 2);
    chk("t4_mode", 32'(bus.ram_mode), 2);
    exp_q = {8'h11, 8'h22};
    chk_writes("t4", exp_q);

    // Directed load 03 A1 B2 C3.
    prog = {8'hA1, 8'hB2, 8'hC3};
    load_program("t2", 8'h03, prog);

    // Debug stepping.
    bus.debug_req = 1'b1; tick(); clear_inputs();
    chk("t5_state", 32'(bus.state), 2);
    chk("t5_mode", 32'(bus.ram_mode), 1);
    chk("t5_dbg_idle", 32'(bus.ram_debug), 0);
    bus.step = 1'b1; tick();
    highs = int'(bus.ram_debug);
    tick(); bus.step = 1'b0;  // second step lands during the hold
    for (int i = 0; i < 5; i++) begin
      highs += int'(bus.ram_debug);
      tick();
    end
    chk("t5_high_clks", 32'(highs), STEP_HOLD);
    bus.step = 1'b1; tick(); bus.step = 1'b0;
    chk("t5_restep", 32'(bus.ram_debug), 1);
    pulse_abort();
    chk("t5_abort_state", 32'(bus.state), 0);
    chk("t5_abort_dbg", 32'(bus.ram_debug), 0);
    tick();

    // IDLE priority: debug_req beats run_req.
    bus.debug_req = 1'b1; bus.run_req = 1'b1; tick(); clear_inputs();
    chk("t6_dbg_over_run", 32'(bus.state), 2);
    pulse_abort();

    // load_req beats debug_req and run_req.
    bus.load_req = 1'b1; bus.debug_req = 1'b1; bus.run_req = 1'b1; tick(); clear_inputs();
    chk("t6_load_wins", 32'(bus.state), 1);
    chk("t6_loaded_clr", 32'(bus.loaded), 0);
    // rx byte coinciding with abort is dropped.
    send(8'h02);
    bus.rx_data = 8'h5A; bus.rx_valid = 1'b1; bus.abort = 1'b1; tick(); clear_inputs();
    chk("t6_abort_load", 32'(bus.state), 0);
    chk("t6_abort_nowr", 32'(bus.ram_load), 0);

    prog = {8'h12, 8'h34};
    load_program("t6_reload", 8'h02, prog);
    bus.run_req = 1'b1; tick(); clear_inputs();
    chk("t6_run_state", 32'(bus.state), 3);
    chk("t6_cpu_en", 32'(bus.cpu_en), 1);
    chk("t6_run_mode", 32'(bus.ram_mode), 2);
    tick();
    chk("t6_cpu_hold", 32'(bus.cpu_en), 1);
    pulse_abort();
    chk("t6_cpu_off", 32'(bus.cpu_en), 0);
    chk("t6_abort_idle", 32'(bus.state), 0);

    // Randomized programs, legal and illegal lengths.
    for (int n = 0; n < 10; n++) begin
      logic [7:0] len;
      if ($urandom_range(0, 3) == 0)
        len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(DEPTH + 1, 255));
      else
        len = 8'($urandom_range(1, DEPTH));
      prog = {};
      for (int i = 0; i < DEPTH; i++) prog.push_back(8'($urandom));
      load_program($sformatf("rnd%0d", n), len, prog);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
